gp_reg_pair: RTL and testbench

- Owns the two 8-bit general-purpose registers R1 and R2 of the down-sampling processor.
- Produces the R1/R2 values consumed by the B-bus read selector, which sits directly downstream.
- Registers load from the ALU result bus (C bus), clear, or increment as pixel row/column counters.
- R1 can cascade its wrap into R2 to form a nested column/row scan.

---
 rtl/gp_reg_pkg.sv | 29 ++
 rtl/gp_reg_pair_if.sv | 34 +++
 rtl/gp_count_reg.sv | 53 +++++
 rtl/gp_reg_pair.sv | 75 +++++++
 tb/tb_gp_reg_pair.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/gp_reg_pkg.sv
// Shared definitions for the R1/R2 general-purpose register pair and the
// B-bus read selector that consumes them.
package gp_reg_pkg;

    localparam int   DATA_W = 8;

    // write_addr encoding, shared with the B-bus selector
    localparam logic REG_R1 = 1'b0;
    localparam logic REG_R2 = 1'b1;

    // Resolved per-register command for one cycle
    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_INC  = 2'd1,
        CMD_LOAD = 2'd2,
        CMD_CLR  = 2'd3
    } reg_cmd_e;

    // Fixed priority: clear beats load beats increment beats hold
    function automatic reg_cmd_e resolve_cmd(input logic clr, input logic load, input logic inc);
        reg_cmd_e cmd;
        if (clr)       cmd = CMD_CLR;
        else if (load) cmd = CMD_LOAD;
        else if (inc)  cmd = CMD_INC;
        else           cmd = CMD_HOLD;
        return cmd;
    endfunction

endpackage

// File: rtl/gp_reg_pair_if.sv
// Command/status bundle between the datapath control and the R1/R2 pair.
interface gp_reg_pair_if
    import gp_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W
) ();

    logic [WIDTH-1:0] c_bus;
    logic             write_en;
    logic             write_addr;
    logic [1:0]       clr;
    logic [1:0]       inc;
    logic             chain_en;

    logic [WIDTH-1:0] R1;
    logic [WIDTH-1:0] R2;
    logic             z1;
    logic             z2;
    logic             r1_wrap;
    logic             r2_wrap;

    // Controller side: issues commands, observes register state
    modport master (
        output c_bus, write_en, write_addr, clr, inc, chain_en,
        input  R1, R2, z1, z2, r1_wrap, r2_wrap
    );

    // Register pair side
    modport slave (
        input  c_bus, write_en, write_addr, clr, inc, chain_en,
        output R1, R2, z1, z2, r1_wrap, r2_wrap
    );

endinterface

// File: rtl/gp_count_reg.sv
// Single clear/load/increment register with terminal count. Incrementing at
// MAX returns to 0 and raises a one-cycle wrap pulse; values loaded above MAX
// count modulo 2^WIDTH without pulsing.
module gp_count_reg
    import gp_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  reg_cmd_e         i_cmd,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q,
    output logic             o_zero,
    output logic             o_at_max,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    // Register update; wrap pulse only from an accepted increment at MAX
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            unique case (i_cmd)
                CMD_CLR:  r_q <= '0;
                CMD_LOAD: r_q <= i_data;
                CMD_INC: begin
                    if (r_q == MAX_V) begin
                        r_q    <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_q <= r_q + WIDTH'(1);
                    end
                end
                CMD_HOLD: r_q <= r_q;
            endcase
        end
    end

    assign o_q      = r_q;
    assign o_zero   = (r_q == '0);
    assign o_at_max = (r_q == MAX_V);
    assign o_wrap   = r_wrap;

endmodule

// File: rtl/gp_reg_pair.sv
// R1/R2 general-purpose register pair. R1 can cascade its wrap into R2 to
// build a nested column/row scan; the cascade looks at R1 before the edge.
module gp_reg_pair
    import gp_reg_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int R1_MAX = 255,
    parameter int R2_MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    gp_reg_pair_if.slave bus
);

    reg_cmd_e         w_r1_cmd;
    reg_cmd_e         w_r2_cmd;
    logic             w_r1_at_max;
    logic             w_r2_at_max;
    logic             w_cascade;
    logic [WIDTH-1:0] w_r1;
    logic [WIDTH-1:0] w_r2;
    logic             w_z1;
    logic             w_z2;
    logic             w_r1_wrap;
    logic             w_r2_wrap;

    // Command resolution and cascade: R2 sees a single increment even when
    // inc[1] and the R1 wrap fire together; a clear/load of R1 kills the cascade
    always_comb begin
        w_r1_cmd  = resolve_cmd(bus.clr[0], bus.write_en && (bus.write_addr == REG_R1), bus.inc[0]);
        w_cascade = bus.chain_en && (w_r1_cmd == CMD_INC) && w_r1_at_max;
        w_r2_cmd  = resolve_cmd(bus.clr[1], bus.write_en && (bus.write_addr == REG_R2),
                                bus.inc[1] || w_cascade);
    end

    gp_count_reg #(
        .WIDTH (WIDTH),
        .MAX   (R1_MAX)
    ) u_r1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cmd    (w_r1_cmd),
        .i_data   (bus.c_bus),
        .o_q      (w_r1),
        .o_zero   (w_z1),
        .o_at_max (w_r1_at_max),
        .o_wrap   (w_r1_wrap)
    );

    gp_count_reg #(
        .WIDTH (WIDTH),
        .MAX   (R2_MAX)
    ) u_r2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_cmd    (w_r2_cmd),
        .i_data   (bus.c_bus),
        .o_q      (w_r2),
        .o_zero   (w_z2),
        .o_at_max (w_r2_at_max),
        .o_wrap   (w_r2_wrap)
    );

    // R2 terminal count only matters inside u_r2; kept visible for debug
    logic w_unused;
    assign w_unused = w_r2_at_max;

    assign bus.R1      = w_r1;
    assign bus.R2      = w_r2;
    assign bus.z1      = w_z1;
    assign bus.z2      = w_z2;
    assign bus.r1_wrap = w_r1_wrap;
    assign bus.r2_wrap = w_r2_wrap;

endmodule

// File: tb/tb_gp_reg_pair.sv
// Bench for gp_reg_pair with R1_MAX = 3 so the chained scan wraps quickly.
module tb_gp_reg_pair;

    logic clk;
    logic rst_n;

    gp_reg_pair_if #(.WIDTH(8)) bus ();

    gp_reg_pair #(
        .WIDTH  (8),
        .R1_MAX (3),
        .R2_MAX (255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rs;
        logic       we;
        logic       wa;
        logic [7:0] c;
        logic [1:0] cl;
        logic [1:0] in;
        logic       ch;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       w1;
        logic       w2;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string n, logic rs, logic we, logic wa, logic [7:0] c,
                                logic [1:0] cl, logic [1:0] in, logic ch,
                                logic [7:0] e1, logic [7:0] e2, logic w1, logic w2);
        vec_t v;
        v.name = n; v.rs = rs; v.we = we; v.wa = wa; v.c = c; v.cl = cl; v.in = in; v.ch = ch;
        v.e1 = e1; v.e2 = e2; v.w1 = w1; v.w2 = w2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one command away from the edge, then compare the registered result
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n        = v.rs;
        bus.write_en = v.we;
        bus.write_addr = v.wa;
        bus.c_bus    = v.c;
        bus.clr      = v.cl;
        bus.inc      = v.in;
        bus.chain_en = v.ch;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({e.name, ".R1"}, 32'(bus.R1), 32'(e.e1));
            chk({e.name, ".R2"}, 32'(bus.R2), 32'(e.e2));
            chk({e.name, ".z1"}, 32'(bus.z1), 32'(e.e1 == 8'd0));
            chk({e.name, ".z2"}, 32'(bus.z2), 32'(e.e2 == 8'd0));
            chk({e.name, ".r1_wrap"}, 32'(bus.r1_wrap), 32'(e.w1));
            chk({e.name, ".r2_wrap"}, 32'(bus.r2_wrap), 32'(e.w2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        logic [7:0] m1;
        logic [7:0] m2;
        logic       mw;

        rst_n = 1'b0;
        bus.write_en = 1'b0; bus.write_addr = 1'b0; bus.c_bus = 8'h00;
        bus.clr = 2'b00; bus.inc = 2'b00; bus.chain_en = 1'b0;

        //                 name               rs we wa c      clr    inc    ch  R1     R2     w1 w2
        tbl.push_back(mk("rst_a",             0, 0, 0, 8'h00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk("rst_ignores_in",    0, 1, 0, 8'h55, 2'b00, 2'b11, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk("idle",              1, 0, 0, 8'h00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk("wr_r2_a5",          1, 1, 1, 8'hA5, 2'b00, 2'b00, 0, 8'h00, 8'hA5, 0, 0));
        tbl.push_back(mk("wr_r1_inc_r2",      1, 1, 0, 8'h02, 2'b00, 2'b10, 0, 8'h02, 8'hA6, 0, 0));
        tbl.push_back(mk("clr_both",          1, 0, 0, 8'h00, 2'b11, 2'b00, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk("scan1",             1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h01, 8'h00, 0, 0));
        tbl.push_back(mk("scan2",             1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h02, 8'h00, 0, 0));
        tbl.push_back(mk("scan3",             1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h03, 8'h00, 0, 0));
        tbl.push_back(mk("scan4_wrap",        1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h00, 8'h01, 1, 0));
        tbl.push_back(mk("scan5",             1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h01, 8'h01, 0, 0));
        tbl.push_back(mk("scan6",             1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h02, 8'h01, 0, 0));
        tbl.push_back(mk("scan7",             1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h03, 8'h01, 0, 0));
        tbl.push_back(mk("scan8_wrap",        1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h00, 8'h02, 1, 0));
        tbl.push_back(mk("set_max_a",         1, 1, 0, 8'h03, 2'b00, 2'b00, 0, 8'h03, 8'h02, 0, 0));
        tbl.push_back(mk("collide_inc11",     1, 0, 0, 8'h00, 2'b00, 2'b11, 1, 8'h00, 8'h03, 1, 0));
        tbl.push_back(mk("set_max_b",         1, 1, 0, 8'h03, 2'b00, 2'b00, 0, 8'h03, 8'h03, 0, 0));
        tbl.push_back(mk("wrap_no_chain",     1, 0, 0, 8'h00, 2'b00, 2'b01, 0, 8'h00, 8'h03, 1, 0));
        tbl.push_back(mk("wr_r1_5",           1, 1, 0, 8'h05, 2'b00, 2'b00, 0, 8'h05, 8'h03, 0, 0));
        tbl.push_back(mk("prio_clr",          1, 1, 0, 8'h33, 2'b01, 2'b01, 0, 8'h00, 8'h03, 0, 0));
        tbl.push_back(mk("prio_wr_over_inc",  1, 1, 0, 8'h33, 2'b00, 2'b01, 0, 8'h33, 8'h03, 0, 0));
        tbl.push_back(mk("set_max_c",         1, 1, 0, 8'h03, 2'b00, 2'b00, 0, 8'h03, 8'h03, 0, 0));
        tbl.push_back(mk("wr_at_max_nocasc",  1, 1, 0, 8'h10, 2'b00, 2'b01, 1, 8'h10, 8'h03, 0, 0));
        tbl.push_back(mk("set_max_d",         1, 1, 0, 8'h03, 2'b00, 2'b00, 0, 8'h03, 8'h03, 0, 0));
        tbl.push_back(mk("clr_at_max_nocasc", 1, 0, 0, 8'h00, 2'b01, 2'b01, 1, 8'h00, 8'h03, 0, 0));
        tbl.push_back(mk("set_max_e",         1, 1, 0, 8'h03, 2'b00, 2'b00, 0, 8'h03, 8'h03, 0, 0));
        tbl.push_back(mk("r2clr_drops_casc",  1, 0, 0, 8'h00, 2'b10, 2'b01, 1, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk("wr_r1_fe",          1, 1, 0, 8'hFE, 2'b00, 2'b00, 0, 8'hFE, 8'h00, 0, 0));
        tbl.push_back(mk("inc_above_max",     1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'hFF, 8'h00, 0, 0));
        tbl.push_back(mk("inc_mod_no_pulse",  1, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk("wr_r2_ff",          1, 1, 1, 8'hFF, 2'b00, 2'b00, 0, 8'h00, 8'hFF, 0, 0));
        tbl.push_back(mk("r2_wrap",           1, 0, 0, 8'h00, 2'b00, 2'b10, 0, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk("r2_pulse_end",      1, 0, 0, 8'h00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk("wr_r2_7",           1, 1, 1, 8'h07, 2'b00, 2'b00, 0, 8'h00, 8'h07, 0, 0));
        tbl.push_back(mk("set_max_f",         1, 1, 0, 8'h03, 2'b00, 2'b00, 0, 8'h03, 8'h07, 0, 0));
        tbl.push_back(mk("rst_mid_scan",      0, 0, 0, 8'h00, 2'b00, 2'b01, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk("post_rst",          1, 0, 0, 8'h00, 2'b00, 2'b00, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk("set_max_g",         1, 1, 0, 8'h03, 2'b00, 2'b00, 0, 8'h03, 8'h00, 0, 0));
        tbl.push_back(mk("r2wr_drops_casc",   1, 1, 1, 8'h40, 2'b00, 2'b01, 1, 8'h00, 8'h40, 1, 0));
        tbl.push_back(mk("set_max_h",         1, 1, 0, 8'h03, 2'b00, 2'b00, 0, 8'h03, 8'h40, 0, 0));
        tbl.push_back(mk("chain_no_inc",      1, 0, 0, 8'h00, 2'b00, 2'b00, 1, 8'h03, 8'h40, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Longer chained scan against a small reference model, counting pulses
        step(mk("seq_clr", 1, 0, 0, 8'h00, 2'b11, 2'b00, 0, 8'h00, 8'h00, 0, 0));
        m1 = 8'h00; m2 = 8'h00; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            mw = (m1 == 8'd3);
            m1 = mw ? 8'h00 : m1 + 8'h01;
            if (mw) m2 = m2 + 8'h01;
            step(mk($sformatf("seq_scan%0d", k), 1, 0, 0, 8'h00, 2'b00, 2'b01, 1, m1, m2, mw, 0));
            if (bus.r1_wrap === 1'b1) pulses++;
        end
        chk("seq_pulse_count", 32'(pulses), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
